// File: rtl/imul_pkg.sv
// imul_pkg: state encoding and derived-width helper shared by the imul_seq multiplier.
// Rev 1.0
`default_nettype none

package imul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } imul_state_e;

  // One extra bit so the counter can represent SIZE itself.
  function automatic int cnt_width(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imul_step_counter.sv
// imul_step_counter: step counter with synchronous clear/enable and terminal count at SIZE-1.
// Rev 1.0
`default_nettype none

module imul_step_counter
  import imul_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int CNT_W = cnt_width(SIZE)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == CNT_W'(SIZE - 1));

endmodule

`default_nettype wire

// File: rtl/imul_seq.sv
// imul_seq: iterative radix-2 shift-add multiplier, one partial product per cycle, Start/Done handshake.
// Optional signed mode via macro IMUL_SEQ_SIGNED_EN. Rev 1.0
`default_nettype none

module imul_seq
  import imul_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int CNT_W = cnt_width(SIZE)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [SIZE-1:0]   MulA,
  input  logic [SIZE-1:0]   MulB,
`ifdef IMUL_SEQ_SIGNED_EN
  input  logic              Signed,
`endif
  output logic              Busy,
  output logic              Done,
  output logic [2*SIZE-1:0] Product
);

  imul_state_e       state_q,   state_d;
  logic [SIZE-1:0]   mcand_q,   mcand_d;
  logic [SIZE-1:0]   shift_q,   shift_d;
  logic [2*SIZE-1:0] acc_q,     acc_d;
  logic [2*SIZE-1:0] product_q, product_d;

  logic [CNT_W-1:0]  step_cnt;
  logic              step_tc;
  logic              accept;
  logic [SIZE-1:0]   a_mag;
  logic [SIZE-1:0]   b_mag;
  logic [2*SIZE-1:0] addend;
  logic [2*SIZE-1:0] sum;
  logic [2*SIZE-1:0] result;

  assign accept = (state_q == S_IDLE) && Start;

  imul_step_counter #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) u_step_counter (
    .Clock    (Clock),
    .Reset    (Reset),
    .clear_i  (accept),
    .enable_i (state_q == S_RUN),
    .count_o  (step_cnt),
    .tc_o     (step_tc)
  );

  assign addend = {{SIZE{1'b0}}, mcand_q} << step_cnt;
  assign sum    = acc_q + (shift_q[0] ? addend : '0);

`ifdef IMUL_SEQ_SIGNED_EN
  logic sign_q, sign_d;

  // The magnitude of -2^(SIZE-1) still fits SIZE unsigned bits.
  assign a_mag  = (Signed && MulA[SIZE-1]) ? -MulA : MulA;
  assign b_mag  = (Signed && MulB[SIZE-1]) ? -MulB : MulB;
  assign result = sign_q ? -sum : sum;

  always_comb begin
    sign_d = sign_q;
    if (accept) begin
      sign_d = Signed & (MulA[SIZE-1] ^ MulB[SIZE-1]);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sign_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
    end
  end
`else
  assign a_mag  = MulA;
  assign b_mag  = MulB;
  assign result = sum;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mcand_d = a_mag;
          shift_d = b_mag;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = sum;
        shift_d = shift_q >> 1;
        if (step_tc) begin
          product_d = result;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      shift_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign Busy    = (state_q != S_IDLE);
  assign Done    = (state_q == S_DONE);
  assign Product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_imul_seq.sv
// tb_imul_seq: table-driven, scoreboarded bench for imul_seq (SIZE=16).
// Rev 1.0
`default_nettype none

module tb_imul_seq;

  localparam int SIZE = 16;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              Start = 1'b0;
  logic [SIZE-1:0]   MulA  = '0;
  logic [SIZE-1:0]   MulB  = '0;
  logic              Busy;
  logic              Done;
  logic [2*SIZE-1:0] Product;
`ifdef IMUL_SEQ_SIGNED_EN
  logic              Signed = 1'b0;
`endif

  imul_seq #(
    .SIZE (SIZE)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (Start),
    .MulA    (MulA),
    .MulB    (MulB),
`ifdef IMUL_SEQ_SIGNED_EN
    .Signed  (Signed),
`endif
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [SIZE-1:0]   a;
    logic [SIZE-1:0]   b;
    logic              s;
    logic [2*SIZE-1:0] exp;
  } vec_t;

  vec_t              vecs[$];
  logic [2*SIZE-1:0] sb_q[$];
  int                n_checks = 0;
  int                n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (Busy !== 1'b0 && k < 50) begin
      @(negedge Clock);
      k++;
    end
    if (k >= 50) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Drive one operation; expected result goes to the scoreboard at accept.
  task automatic run_op(input string name, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic s, input logic [2*SIZE-1:0] exp);
    logic [2*SIZE-1:0] prev;
    int                cyc;
    bit                glitch;
    @(negedge Clock);
    wait_idle();
    prev  = Product;
    Start = 1'b1;
    MulA  = a;
    MulB  = b;
`ifdef IMUL_SEQ_SIGNED_EN
    Signed = s;
`else
    if (s) $display("note: %s signed vector applied as unsigned", name);
`endif
    sb_q.push_back(exp);
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    MulA  = SIZE'($urandom);
    MulB  = SIZE'($urandom);
    check({name, "_busy"}, {31'd0, Busy}, 32'd1);
    glitch = 1'b0;
    cyc    = 0;
    while (Done !== 1'b1 && cyc < 40) begin
      if (Product !== prev) glitch = 1'b1;
      @(negedge Clock);
      cyc++;
    end
    check({name, "_latency"}, cyc, SIZE);
    check({name, "_stable"}, {31'd0, glitch}, 32'd0);
    if (sb_q.size() > 0) check({name, "_product"}, Product, sb_q.pop_front());
    else check({name, "_sb_empty"}, 32'd1, 32'd0);
    @(negedge Clock);
    check({name, "_done_pulse"}, {30'd0, Done, Busy}, 32'd0);
    check({name, "_hold"}, Product, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  cyc;
    bit  saw_done;
    logic [SIZE-1:0] ra, rb;

    vecs.push_back('{a: 16'd3,    b: 16'd5,    s: 1'b0, exp: 32'h0000000F});
    vecs.push_back('{a: 16'hFFFF, b: 16'hFFFF, s: 1'b0, exp: 32'hFFFE0001});
    vecs.push_back('{a: 16'd0,    b: 16'h1234, s: 1'b0, exp: 32'h00000000});
    vecs.push_back('{a: 16'd12,   b: 16'd12,   s: 1'b0, exp: 32'd144});
    vecs.push_back('{a: 16'd1,    b: 16'd1,    s: 1'b0, exp: 32'd1});
    vecs.push_back('{a: 16'hFFFD, b: 16'd5,    s: 1'b0, exp: 32'h0004FFF1});
    vecs.push_back('{a: 16'h8000, b: 16'h8000, s: 1'b0, exp: 32'h40000000});
`ifdef IMUL_SEQ_SIGNED_EN
    vecs.push_back('{a: 16'hFFFD, b: 16'd5,    s: 1'b1, exp: 32'hFFFFFFF1});
    vecs.push_back('{a: 16'h8000, b: 16'h8000, s: 1'b1, exp: 32'h40000000});
    vecs.push_back('{a: 16'hFFFF, b: 16'hFFFF, s: 1'b1, exp: 32'h00000001});
    vecs.push_back('{a: 16'd7,    b: 16'hFFF7, s: 1'b1, exp: 32'hFFFFFFC1});
`endif
    for (int i = 0; i < 4; i++) begin
      ra = SIZE'($urandom);
      rb = SIZE'($urandom);
      vecs.push_back('{a: ra, b: rb, s: 1'b0, exp: 32'(ra) * 32'(rb)});
    end

    // Reset held two cycles.
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("reset_product", Product, 32'd0);
    check("reset_flags", {30'd0, Busy, Done}, 32'd0);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);
    end

    // Reset during RUN aborts without a Done.
    @(negedge Clock);
    wait_idle();
    Start = 1'b1;
    MulA  = 16'd100;
    MulB  = 16'd200;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    check("abort_flags", {30'd0, Busy, Done}, 32'd0);
    check("abort_product", Product, 32'd0);
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge Clock);
      if (Done === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    check("abort_product_idle", Product, 32'd0);
    run_op("after_abort", 16'd2, 16'd2, 1'b0, 32'd4);

    // Start held high: re-accepted only once the FSM is back in IDLE.
    @(negedge Clock);
    wait_idle();
    Start = 1'b1;
    MulA  = 16'd7;
    MulB  = 16'd9;
    for (int rep = 0; rep < 2; rep++) begin
      cyc = 0;
      while (Done !== 1'b1 && cyc < 40) begin
        @(negedge Clock);
        cyc++;
      end
      check($sformatf("held%0d_done_seen", rep), {31'd0, Done}, 32'd1);
      check($sformatf("held%0d_product", rep), Product, 32'd63);
      @(negedge Clock);
      check($sformatf("held%0d_idle_gap", rep), {31'd0, Busy}, 32'd0);
      @(negedge Clock);
      check($sformatf("held%0d_reaccept", rep), {31'd0, Busy}, 32'd1);
    end
    Start = 1'b0;
    cyc = 0;
    while (Done !== 1'b1 && cyc < 40) begin
      @(negedge Clock);
      cyc++;
    end
    check("held_last_product", Product, 32'd63);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
